mips_mem_arbiter: RTL and testbench
===================================

Name: mips_mem_arbiter

Overview:
Arbiter and sequencer for the single-port unified instruction/data memory of the single-clock MIPS32 core. It shares the memory between three requesters: debug/program loader (DBG), data-memory stage LW/SW (DM) and instruction fetch (IF). It serialises accesses with a fixed-latency FSM and generates the fetch stall. A starvation guard keeps fetch from being locked out by back-to-back loads and stores.

Parameters:
AW, 10, word-address width
DW, 32, data width
MEM_LAT, 1, memory read latency in cycles after the mem_en cycle; legal range 1..4
MAX_WAIT, 4, number of consecutive denied IF arbitration cycles before IF is promoted above DM

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  AW  fetch word address
if_gnt  out  1  fetch accepted (one-cycle pulse)
if_rvalid  out  1  fetch data valid on rdata (one-cycle pulse)
if_stall  out  1  if_req & ~if_gnt
dm_req  in  1  data request
dm_we  in  1  1 = store (SW), 0 = load (LW)
dm_addr  in  AW  data word address
dm_wdata  in  DW  store data
dm_gnt  out  1  data accepted
dm_rvalid  out  1  load data valid, or store acknowledge
dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/DW  loader request; same semantics as DM
dbg_gnt, dbg_rvalid  out  1/1  loader grant and response
rdata  out  DW  shared response data, qualified by the *_rvalid signals
mem_en, mem_we  out  1/1  memory strobe and write enable
mem_addr, mem_wdata  out  AW/DW  memory address and write data
mem_rdata  in  DW  memory read data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, owner=NONE, starve_cnt=0.
  - All gnt, rvalid, mem_en and mem_we are 0; rdata, mem_addr and mem_wdata are 0.
  - A transaction in flight is dropped with no rvalid; requesters must reissue.
- States and transitions:
  - IDLE -> ISSUE when any req is high.
  - ISSUE -> WAIT after exactly 1 cycle.
  - WAIT -> IDLE after exactly MEM_LAT cycles.
- IDLE:
  - Combinational priority pick. Normal order: DBG > DM > IF. Promoted order (starve_cnt >= MAX_WAIT): DBG > IF > DM.
  - The winner's gnt is high in this same cycle.
  - The winner's addr, we, wdata and identity are latched at the edge.
  - Losers receive no gnt and must hold their req.
- ISSUE: mem_en=1, with mem_we, mem_addr and mem_wdata driven from the latched registers. This is the only cycle mem_en is high.
- WAIT:
  - A down-counter is loaded with MEM_LAT.
  - In the last WAIT cycle, mem_rdata is captured into rdata; it is forced to 0 for writes.
- Response: the owner's rvalid is high for exactly 1 cycle, registered, in the cycle the FSM is back in IDLE. A new grant may occur in that same cycle.
- Latency: gnt in cycle 0 -> mem_en in cycle 1 -> rvalid in cycle 2+MEM_LAT. Back-to-back grants are spaced 2+MEM_LAT cycles apart.
- Outstanding transactions: only one at a time. gnt is never asserted outside IDLE.
- starve_cnt (saturating, width $clog2(MAX_WAIT+1)):
  - Increments on each IDLE cycle where if_req=1 and IF loses.
  - Clears on an IF grant, or on any cycle with if_req=0.
  - Does not change in ISSUE or WAIT.
- DBG always wins, even when IF is promoted; the loader is only active while the core is halted or under reset.
- A req that drops before its gnt is simply not served; no error is raised.
- Writes complete with rvalid as an acknowledge; stores are never posted.
- Simultaneous events: a response to requester X and a new grant to requester X in the same cycle is legal. rdata then belongs to the completing transaction.

Optional Feature:
MIPS_ARB_PERF_CNT_EN:
- Defined: adds outputs conflict_cnt[31:0] and if_starve_cnt[31:0].
  - conflict_cnt counts IDLE cycles with 2 or more reqs high.
  - if_starve_cnt counts cycles where if_stall=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mips_mem_pkg holds:
  - owner enum: OWN_NONE, OWN_IF, OWN_DM, OWN_DBG
  - state enum: ST_IDLE, ST_ISSUE, ST_WAIT
  - the MIPS_DW=32 constant
- Sub-module mips_arb_prio: purely combinational.
  - Inputs: three reqs plus the promote flag.
  - Outputs: one-hot grant and winner owner code.

Test Plan:
- Single IF read, addr 7, Mem[7]=0xDEAD_BEEF, MEM_LAT=1:
  - if_gnt in cycle 0, mem_en in cycle 1, if_rvalid in cycle 3 with rdata=0xDEADBEEF.
  - if_stall is 0 in cycle 0.
- IF and DM requested together, dm_we=0, addr 10, Mem[10]=50:
  - DM granted first, rdata=50.
  - if_stall=1 until IF is granted in DM's rvalid cycle (cycle 3).
- Continuous DM traffic with if_req held high, MAX_WAIT=4:
  - IF loses 4 arbitration rounds, then wins the 5th.
  - starve_cnt returns to 0 after the IF grant.
- DBG store addr 0 data 0x2001_0005 while DM and IF are also requesting:
  - dbg_gnt wins; mem_we=1 in the ISSUE cycle; dbg_rvalid arrives with rdata=0.
  - A subsequent IF read of addr 0 returns 0x20010005.
- rst_n pulled low during WAIT of a DM read:
  - mem_en, dm_rvalid and the gnts drop immediately (asynchronous).
  - After release, no stale rvalid; a reissued request completes normally.
- MEM_LAT=3 read:
  - rvalid exactly 5 cycles after gnt.
  - With MIPS_ARB_PERF_CNT_EN defined, conflict_cnt increments only on multi-request IDLE cycles.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS32 unified-memory arbiter.
package mips_mem_pkg;

    localparam int MIPS_DW = 32;

    // Bit positions inside the one-hot grant / rvalid vectors
    localparam int GNT_IF  = 0;
    localparam int GNT_DM  = 1;
    localparam int GNT_DBG = 2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2,
        OWN_DBG  = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    function automatic logic [2:0] owner_onehot(input owner_e own);
        logic [2:0] oh;
        oh = 3'b000;
        case (own)
            OWN_IF:  oh[GNT_IF]  = 1'b1;
            OWN_DM:  oh[GNT_DM]  = 1'b1;
            OWN_DBG: oh[GNT_DBG] = 1'b1;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mips_arb_prio.sv
// Combinational priority pick: DBG > DM > IF, or DBG > IF > DM while IF is promoted.
module mips_arb_prio
    import mips_mem_pkg::*;
(
    input  logic       if_req,
    input  logic       dm_req,
    input  logic       dbg_req,
    input  logic       promote,
    output logic [2:0] gnt_oh,
    output owner_e     winner
);

    always_comb begin
        gnt_oh = 3'b000;
        winner = OWN_NONE;
        if (dbg_req) begin
            gnt_oh[GNT_DBG] = 1'b1;
            winner          = OWN_DBG;
        end else if (promote && if_req) begin
            gnt_oh[GNT_IF] = 1'b1;
            winner         = OWN_IF;
        end else if (dm_req) begin
            gnt_oh[GNT_DM] = 1'b1;
            winner         = OWN_DM;
        end else if (if_req) begin
            gnt_oh[GNT_IF] = 1'b1;
            winner         = OWN_IF;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter/sequencer for IF, DM and debug loader.
// Optional perf counters (conflict_cnt, if_starve_cnt) under `MIPS_ARB_PERF_CNT_EN`.
//   state    | meaning
//   ST_IDLE  | arbitrate; grant and latch the winning request
//   ST_ISSUE | single mem_en strobe from the latched request
//   ST_WAIT  | MEM_LAT-cycle down-count, capture rdata in the last cycle
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW       = 10,
    parameter int DW       = MIPS_DW,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
`ifdef MIPS_ARB_PERF_CNT_EN
    output logic [31:0]   conflict_cnt,
    output logic [31:0]   if_starve_cnt,
`endif
    input  logic [DW-1:0] mem_rdata
);

    localparam int LCW = $clog2(MEM_LAT + 1);
    localparam int SCW = $clog2(MAX_WAIT + 1);

    state_e         state_q,      state_d;
    owner_e         owner_q,      owner_d;
    logic [AW-1:0]  addr_q,       addr_d;
    logic           we_q,         we_d;
    logic [DW-1:0]  wdata_q,      wdata_d;
    logic [LCW-1:0] lat_cnt_q,    lat_cnt_d;
    logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
    logic [DW-1:0]  rdata_q,      rdata_d;
    logic [2:0]     rvalid_q,     rvalid_d;

    logic [2:0] arb_gnt;
    logic [2:0] gnt;
    owner_e     arb_owner;
    logic       promote;

    assign promote = (starve_cnt_q >= SCW'(MAX_WAIT));

    // Requests are masked by rst_n so no grant can appear while reset is held.
    mips_arb_prio u_prio (
        .if_req  (if_req  & rst_n),
        .dm_req  (dm_req  & rst_n),
        .dbg_req (dbg_req & rst_n),
        .promote (promote),
        .gnt_oh  (arb_gnt),
        .winner  (arb_owner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        rdata_d      = rdata_q;
        rvalid_d     = 3'b000;
        gnt          = 3'b000;

        case (state_q)
            ST_IDLE: begin
                gnt = arb_gnt;
                if (|arb_gnt) begin
                    state_d = ST_ISSUE;
                    owner_d = arb_owner;
                    case (arb_owner)
                        OWN_DBG: begin
                            addr_d  = dbg_addr;
                            we_d    = dbg_we;
                            wdata_d = dbg_wdata;
                        end
                        OWN_DM: begin
                            addr_d  = dm_addr;
                            we_d    = dm_we;
                            wdata_d = dm_wdata;
                        end
                        OWN_IF: begin
                            addr_d  = if_addr;
                            we_d    = 1'b0;
                            wdata_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ISSUE: begin
                state_d   = ST_WAIT;
                lat_cnt_d = LCW'(MEM_LAT);
            end
            ST_WAIT: begin
                if (lat_cnt_q == LCW'(1)) begin
                    state_d  = ST_IDLE;
                    rdata_d  = we_q ? '0 : mem_rdata;
                    rvalid_d = owner_onehot(owner_q);
                    owner_d  = OWN_NONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A withdrawn fetch request forgets its accumulated starvation in any state.
        if (!if_req) begin
            starve_cnt_d = '0;
        end else if (state_q == ST_IDLE) begin
            if (gnt[GNT_IF]) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != '1) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 3'b000;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign if_gnt     = gnt[GNT_IF];
    assign dm_gnt     = gnt[GNT_DM];
    assign dbg_gnt    = gnt[GNT_DBG];
    assign if_stall   = if_req & ~if_gnt;
    assign if_rvalid  = rvalid_q[GNT_IF];
    assign dm_rvalid  = rvalid_q[GNT_DM];
    assign dbg_rvalid = rvalid_q[GNT_DBG];
    assign rdata      = rdata_q;

    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

`ifdef MIPS_ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt_q,  conflict_cnt_d;
    logic [31:0] if_starve_cnt_q, if_starve_cnt_d;
    logic        multi_req;

    assign multi_req = (if_req & dm_req) | (if_req & dbg_req) | (dm_req & dbg_req);

    always_comb begin
        conflict_cnt_d  = conflict_cnt_q;
        if_starve_cnt_d = if_starve_cnt_q;
        if ((state_q == ST_IDLE) && multi_req) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
        if (if_stall) begin
            if_starve_cnt_d = if_starve_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_q  <= '0;
            if_starve_cnt_q <= '0;
        end else begin
            conflict_cnt_q  <= conflict_cnt_d;
            if_starve_cnt_q <= if_starve_cnt_d;
        end
    end

    assign conflict_cnt  = conflict_cnt_q;
    assign if_starve_cnt = if_starve_cnt_q;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: MEM_LAT=1 instance driven from a vector table and
// corner sequences with a response scoreboard, plus a MEM_LAT=3 instance.
`timescale 1ns/1ps
module tb_mips_mem_arbiter;
    import mips_mem_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A (MEM_LAT=1) ----------------
    logic          if_req, if_gnt, if_rvalid, if_stall;
    logic [AW-1:0] if_addr;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
`ifdef MIPS_ARB_PERF_CNT_EN
    logic [31:0]   a_conflict_cnt, a_if_starve_cnt;
`endif

    mips_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT_A), .MAX_WAIT(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef MIPS_ARB_PERF_CNT_EN
        .conflict_cnt(a_conflict_cnt), .if_starve_cnt(a_if_starve_cnt),
`endif
        .mem_rdata(mem_rdata)
    );

    logic [DW-1:0] mem_a  [0:(1<<AW)-1];
    logic [DW-1:0] pipe_a [0:LAT_A-1];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < (1<<AW); i++) mem_a[i] <= '0;
            mem_a[7]  <= 32'hDEAD_BEEF;
            mem_a[10] <= 32'd50;
            mem_a[3]  <= 32'h0000_0333;
            for (int i = 0; i < LAT_A; i++) pipe_a[i] <= '0;
        end else begin
            if (mem_en && mem_we) mem_a[mem_addr] <= mem_wdata;
            pipe_a[0] <= mem_en ? mem_a[mem_addr] : 32'hBAD0_BAD0;
            for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
        end
    end
    assign mem_rdata = pipe_a[LAT_A-1];

    // ---------------- DUT B (MEM_LAT=3) ----------------
    logic          b_if_req, b_if_gnt, b_if_rvalid, b_if_stall;
    logic [AW-1:0] b_if_addr;
    logic          b_dm_req, b_dm_we, b_dm_gnt, b_dm_rvalid;
    logic [AW-1:0] b_dm_addr;
    logic [DW-1:0] b_dm_wdata;
    logic          b_dbg_req, b_dbg_we, b_dbg_gnt, b_dbg_rvalid;
    logic [AW-1:0] b_dbg_addr;
    logic [DW-1:0] b_dbg_wdata;
    logic [DW-1:0] b_rdata, b_mem_wdata, b_mem_rdata;
    logic          b_mem_en, b_mem_we;
    logic [AW-1:0] b_mem_addr;
`ifdef MIPS_ARB_PERF_CNT_EN
    logic [31:0]   b_conflict_cnt, b_if_starve_cnt;
`endif

    mips_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT_B), .MAX_WAIT(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_stall(b_if_stall),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid),
        .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
        .dbg_gnt(b_dbg_gnt), .dbg_rvalid(b_dbg_rvalid),
        .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
`ifdef MIPS_ARB_PERF_CNT_EN
        .conflict_cnt(b_conflict_cnt), .if_starve_cnt(b_if_starve_cnt),
`endif
        .mem_rdata(b_mem_rdata)
    );

    logic [DW-1:0] mem_b  [0:(1<<AW)-1];
    logic [DW-1:0] pipe_b [0:LAT_B-1];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < (1<<AW); i++) mem_b[i] <= '0;
            mem_b[5] <= 32'h0BAD_F00D;
            mem_b[6] <= 32'h0000_0066;
            for (int i = 0; i < LAT_B; i++) pipe_b[i] <= '0;
        end else begin
            if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
            pipe_b[0] <= b_mem_en ? mem_b[b_mem_addr] : 32'hBAD0_BAD0;
            for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign b_mem_rdata = pipe_b[LAT_B-1];

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        owner_e        own;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sbq[$];

    task automatic push_exp(input owner_e o, input logic [DW-1:0] d, input int due);
        exp_t e;
        e.own  = o;
        e.data = d;
        e.due  = due;
        sbq.push_back(e);
    endtask

    // Scoreboard for DUT A responses
    always @(negedge clk) begin
        exp_t   e;
        owner_e got;
        if (rst_n && (if_rvalid || dm_rvalid || dbg_rvalid)) begin
            got = if_rvalid ? OWN_IF : (dm_rvalid ? OWN_DM : OWN_DBG);
            chk("rvalid_onehot", 32'($countones({dbg_rvalid, dm_rvalid, if_rvalid})), 32'd1);
            if (sbq.size() == 0) begin
                chk("unexpected_rvalid", 32'(got), 32'(OWN_NONE));
            end else begin
                e = sbq.pop_front();
                chk("sb_owner", 32'(got), 32'(e.own));
                chk("sb_rdata", rdata, e.data);
                chk("sb_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic idle_a();
        if_req = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic idle_b();
        b_if_req = 0; b_if_addr = '0;
        b_dm_req = 0; b_dm_we = 0; b_dm_addr = '0; b_dm_wdata = '0;
        b_dbg_req = 0; b_dbg_we = 0; b_dbg_addr = '0; b_dbg_wdata = '0;
    endtask

    task automatic set_req(input owner_e o, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        case (o)
            OWN_IF:  begin if_req = 1; if_addr = a; end
            OWN_DM:  begin dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = d; end
            OWN_DBG: begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
            default: ;
        endcase
    endtask

    task automatic clr_req(input owner_e o);
        case (o)
            OWN_IF:  if_req = 0;
            OWN_DM:  dm_req = 0;
            OWN_DBG: dbg_req = 0;
            default: ;
        endcase
    endtask

    function automatic logic gnt_of(input owner_e o);
        case (o)
            OWN_IF:  return if_gnt;
            OWN_DM:  return dm_gnt;
            OWN_DBG: return dbg_gnt;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_gnt(input owner_e o, input string nm, output int g);
        g = -1;
        for (int k = 0; k < 20; k++) begin
            if (gnt_of(o)) begin
                g = cyc;
                break;
            end
            @(negedge clk); #1;
        end
        chk({nm, "_gnt_seen"}, 32'(g >= 0), 32'd1);
    endtask

    task automatic wait_drain(input string nm);
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_drained"}, 32'(sbq.size()), 32'd0);
        sbq.delete();
        @(negedge clk);
    endtask

    typedef struct {
        string         nm;
        owner_e        own;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs[10];

    task automatic run_vec(input vec_t v);
        int g;
        @(negedge clk);
        set_req(v.own, v.we, v.addr, v.wdata);
        #1;
        wait_gnt(v.own, v.nm, g);
        if (g >= 0) begin
            chk({v.nm, "_if_stall"}, 32'(if_stall), 32'd0);
            push_exp(v.own, v.exp, g + 2 + LAT_A);
            @(negedge clk);
            clr_req(v.own);
            #1;
            chk({v.nm, "_mem_en"}, 32'(mem_en), 32'd1);
            chk({v.nm, "_mem_we"}, 32'(mem_we), 32'(v.we));
            chk({v.nm, "_mem_addr"}, 32'(mem_addr), 32'(v.addr));
            if (v.we) chk({v.nm, "_mem_wdata"}, mem_wdata, v.wdata);
            @(negedge clk); #1;
            chk({v.nm, "_mem_en_once"}, 32'(mem_en), 32'd0);
        end
        clr_req(v.own);
        wait_drain(v.nm);
    endtask

    task automatic b_expect_rv(input owner_e o, input int due, input logic [DW-1:0] d, input string nm);
        logic rv;
        for (int k = 0; k < 12; k++) begin
            if (cyc > due + 1) break;
            rv = (o == OWN_IF) ? b_if_rvalid : b_dm_rvalid;
            chk($sformatf("%s_rvalid_c%0d", nm, cyc), 32'(rv), 32'(cyc == due));
            if (cyc == due) chk({nm, "_rdata"}, b_rdata, d);
            @(negedge clk); #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int g, gi, g0, n_dm;

        vecs[0] = '{"if_rd7",    OWN_IF,  1'b0, 10'd7,    32'd0,          32'hDEAD_BEEF};
        vecs[1] = '{"dm_rd10",   OWN_DM,  1'b0, 10'd10,   32'd0,          32'd50};
        vecs[2] = '{"dm_wr20",   OWN_DM,  1'b1, 10'd20,   32'h1234_5678,  32'd0};
        vecs[3] = '{"if_rd20",   OWN_IF,  1'b0, 10'd20,   32'd0,          32'h1234_5678};
        vecs[4] = '{"dbg_wr0",   OWN_DBG, 1'b1, 10'd0,    32'hA5A5_0000,  32'd0};
        vecs[5] = '{"if_rd0",    OWN_IF,  1'b0, 10'd0,    32'd0,          32'hA5A5_0000};
        vecs[6] = '{"dbg_rd7",   OWN_DBG, 1'b0, 10'd7,    32'd0,          32'hDEAD_BEEF};
        vecs[7] = '{"dm_wr1023", OWN_DM,  1'b1, 10'd1023, 32'hFFFF_FFFF,  32'd0};
        vecs[8] = '{"dm_rd1023", OWN_DM,  1'b0, 10'd1023, 32'd0,          32'hFFFF_FFFF};
        vecs[9] = '{"dbg_rd20",  OWN_DBG, 1'b0, 10'd20,   32'd0,          32'h1234_5678};

        idle_a();
        idle_b();
        rst_n = 0;
        repeat (2) @(negedge clk);

        // Reset: every output quiet even with all requests raised
        set_req(OWN_IF, 1'b0, 10'd7, '0);
        set_req(OWN_DM, 1'b1, 10'd9, 32'hFFFF_0000);
        set_req(OWN_DBG, 1'b1, 10'd8, 32'h1111_2222);
        #1;
        chk("rst_gnts", 32'({dbg_gnt, dm_gnt, if_gnt}), 32'd0);
        chk("rst_rvalids", 32'({dbg_rvalid, dm_rvalid, if_rvalid}), 32'd0);
        chk("rst_mem_ctl", 32'({mem_en, mem_we}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_starve", 32'(dut_a.starve_cnt_q), 32'd0);
        idle_a();
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Starvation: DM back-to-back with IF held; IF wins the 5th round
        @(negedge clk);
        set_req(OWN_IF, 1'b0, 10'd7, '0);
        set_req(OWN_DM, 1'b0, 10'd10, '0);
        #1;
        n_dm = 0; gi = -1; g0 = -1;
        for (int k = 0; k < 40 && gi < 0; k++) begin
            if (dm_gnt) begin
                if (g0 < 0) g0 = cyc;
                n_dm++;
                push_exp(OWN_DM, 32'd50, cyc + 2 + LAT_A);
            end
            if (if_gnt) begin
                gi = cyc;
                push_exp(OWN_IF, 32'hDEAD_BEEF, cyc + 2 + LAT_A);
            end
            if (gi < 0) begin @(negedge clk); #1; end
        end
        chk("starve_if_granted", 32'(gi >= 0), 32'd1);
        chk("starve_dm_rounds", 32'(n_dm), 32'd4);
        chk("starve_if_cycle", 32'(gi - g0), 32'(4 * (2 + LAT_A)));
        @(negedge clk);
        clr_req(OWN_IF);
        clr_req(OWN_DM);
        set_req(OWN_IF, 1'b0, 10'd3, '0);
        #1;
        chk("starve_cleared", 32'(dut_a.starve_cnt_q), 32'd0);
        clr_req(OWN_IF);
        wait_drain("starve");

        // IF + DM together: DM first, IF granted in DM's rvalid cycle
        @(negedge clk);
        set_req(OWN_IF, 1'b0, 10'd3, '0);
        set_req(OWN_DM, 1'b0, 10'd10, '0);
        #1;
        chk("both_dm_gnt", 32'(dm_gnt), 32'd1);
        chk("both_if_gnt", 32'(if_gnt), 32'd0);
        chk("both_if_stall", 32'(if_stall), 32'd1);
        g = cyc;
        push_exp(OWN_DM, 32'd50, g + 2 + LAT_A);
        @(negedge clk);
        clr_req(OWN_DM);
        #1;
        chk("both_if_stall_issue", 32'(if_stall), 32'd1);
        wait_gnt(OWN_IF, "both_if", gi);
        chk("both_if_gnt_cycle", 32'(gi), 32'(g + 2 + LAT_A));
        if (gi >= 0) push_exp(OWN_IF, 32'h0000_0333, gi + 2 + LAT_A);
        @(negedge clk);
        clr_req(OWN_IF);
        wait_drain("both");

        // DBG store wins over DM and IF; IF then reads the stored word
        @(negedge clk);
        set_req(OWN_DBG, 1'b1, 10'd0, 32'h2001_0005);
        set_req(OWN_DM, 1'b0, 10'd10, '0);
        set_req(OWN_IF, 1'b0, 10'd0, '0);
        #1;
        chk("dbg_gnt_only", 32'({dbg_gnt, dm_gnt, if_gnt}), 32'b100);
        push_exp(OWN_DBG, 32'd0, cyc + 2 + LAT_A);
        @(negedge clk);
        clr_req(OWN_DBG);
        clr_req(OWN_DM);
        #1;
        chk("dbg_mem_we", 32'(mem_we), 32'd1);
        chk("dbg_mem_wdata", mem_wdata, 32'h2001_0005);
        wait_gnt(OWN_IF, "dbg_then_if", gi);
        if (gi >= 0) push_exp(OWN_IF, 32'h2001_0005, gi + 2 + LAT_A);
        @(negedge clk);
        clr_req(OWN_IF);
        wait_drain("dbg_seq");

        // Async reset during WAIT of a DM read drops everything
        @(negedge clk);
        set_req(OWN_DM, 1'b0, 10'd10, '0);
        #1;
        wait_gnt(OWN_DM, "rst_wait", g);
        @(negedge clk);
        clr_req(OWN_DM);
        @(negedge clk);
        set_req(OWN_DM, 1'b0, 10'd10, '0);
        set_req(OWN_IF, 1'b0, 10'd7, '0);
        #1;
        rst_n = 0;
        #1;
        chk("rstw_mem_en", 32'(mem_en), 32'd0);
        chk("rstw_gnts", 32'({dbg_gnt, dm_gnt, if_gnt}), 32'd0);
        chk("rstw_dm_rvalid", 32'(dm_rvalid), 32'd0);
        chk("rstw_mem_addr", 32'(mem_addr), 32'd0);
        idle_a();
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("rstw_no_stale", 32'({dbg_rvalid, dm_rvalid, if_rvalid}), 32'd0);
        end
        run_vec(vecs[1]);

        // MEM_LAT=3 instance: rvalid exactly 5 cycles after gnt
        @(negedge clk);
        b_dm_req = 1; b_dm_we = 0; b_dm_addr = 10'd5;
        #1;
        chk("lat3_dm_gnt", 32'(b_dm_gnt), 32'd1);
        g = cyc;
        @(negedge clk);
        b_dm_req = 0;
        #1;
        b_expect_rv(OWN_DM, g + 2 + LAT_B, 32'h0BAD_F00D, "lat3_dm");
`ifdef MIPS_ARB_PERF_CNT_EN
        chk("perf_conflict_single", b_conflict_cnt, 32'd0);
        chk("perf_starve_single", b_if_starve_cnt, 32'd0);
`endif

        @(negedge clk);
        b_dm_req = 1; b_dm_we = 0; b_dm_addr = 10'd5;
        b_if_req = 1; b_if_addr = 10'd6;
        #1;
        chk("lat3_both_dm_gnt", 32'({b_dm_gnt, b_if_gnt}), 32'b10);
        g = cyc;
        for (int k = 1; k <= 2 + LAT_B; k++) begin
            @(negedge clk);
            if (k == 1) b_dm_req = 0;
            #1;
            chk($sformatf("lat3_both_if_gnt_k%0d", k), 32'(b_if_gnt), 32'(k == 2 + LAT_B));
            if (k == 2 + LAT_B) begin
                chk("lat3_both_dm_rvalid", 32'(b_dm_rvalid), 32'd1);
                chk("lat3_both_dm_rdata", b_rdata, 32'h0BAD_F00D);
            end
        end
        gi = cyc;
        @(negedge clk);
        b_if_req = 0;
        #1;
        b_expect_rv(OWN_IF, gi + 2 + LAT_B, 32'h0000_0066, "lat3_if");
`ifdef MIPS_ARB_PERF_CNT_EN
        chk("perf_conflict_dual", b_conflict_cnt, 32'd1);
        chk("perf_starve_dual", b_if_starve_cnt, 32'd5);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
